// File: rtl/line_sum_accumulator.sv
// ---------------------------------------------------------------------------
// line_sum_accumulator
// Purpose: sums WINDOW_LINES consecutive adder-tree line sums into one window
//          correlation sum and presents it on a valid/ready output handshake.
// Optional feature: define PEAK_TRACK_EN to add tracking of the peak accepted
//          window sum and its window index.
// Ports:
//   CLK              rising-edge clock
//   RST              asynchronous active-high reset
//   en               level enable; low forces IDLE, high runs windows back to back
//   line_sum_in      line sum from adder tree
//   line_sum_valid   line_sum_in valid this cycle
//   window_sum_out   completed window sum (registered)
//   window_sum_valid window_sum_out valid, held until accepted
//   out_ready        consumer ready; transfer on valid && ready at CLK edge
//   line_cnt         lines accumulated in the current window
//   overrun          sticky flag: a line sum arrived while a result was held
//   peak_sum_out     (PEAK_TRACK_EN) largest accepted window sum
//   peak_idx_out     (PEAK_TRACK_EN) index of that window since en rose
// ---------------------------------------------------------------------------
module line_sum_accumulator #(
   parameter int unsigned PIXEL_SIZE   = 8,
   parameter int unsigned LINE_SIZE    = 8,
   parameter int unsigned WINDOW_LINES = 8
) (
   input  logic                                                          CLK,
   input  logic                                                          RST,
   input  logic                                                          en,
   input  logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE-1:0]                     line_sum_in,
   input  logic                                                          line_sum_valid,
   output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE+$clog2(WINDOW_LINES)-1:0] window_sum_out,
   output logic                                                          window_sum_valid,
   input  logic                                                          out_ready,
   output logic [$clog2(WINDOW_LINES)-1:0]                               line_cnt,
`ifdef PEAK_TRACK_EN
   output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE+$clog2(WINDOW_LINES)-1:0] peak_sum_out,
   output logic [15:0]                                                   peak_idx_out,
`endif
   output logic                                                          overrun
);

   localparam int unsigned LINE_SUM_W = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
   localparam int unsigned ACC_W      = LINE_SUM_W + $clog2(WINDOW_LINES);
   localparam int unsigned CNT_W      = $clog2(WINDOW_LINES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] line_sum_ext;
   logic             last_line;
   logic             accept;

`ifdef PEAK_TRACK_EN
   logic [15:0]      win_idx;
`endif

   assign line_sum_ext = ACC_W'(line_sum_in);
   assign last_line    = (line_cnt == CNT_W'(WINDOW_LINES - 1));
   assign accept       = window_sum_valid && out_ready;

   // Window FSM with all outputs registered; en low overrides everything but RST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state            <= IDLE;
         acc              <= '0;
         line_cnt         <= '0;
         window_sum_out   <= '0;
         window_sum_valid <= 1'b0;
         overrun          <= 1'b0;
`ifdef PEAK_TRACK_EN
         peak_sum_out     <= '0;
         peak_idx_out     <= '0;
         win_idx          <= '0;
`endif
      end else if (!en) begin
         state            <= IDLE;
         acc              <= '0;
         line_cnt         <= '0;
         window_sum_valid <= 1'b0;
         overrun          <= 1'b0;
`ifdef PEAK_TRACK_EN
         peak_sum_out     <= '0;
         peak_idx_out     <= '0;
         win_idx          <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               acc      <= '0;
               line_cnt <= '0;
               state    <= ACCUM;
            end

            ACCUM: begin
               if (line_sum_valid) begin
                  if (last_line) begin
                     window_sum_out   <= acc + line_sum_ext;
                     window_sum_valid <= 1'b1;
                     acc              <= '0;
                     line_cnt         <= '0;
                     state            <= HOLD;
                  end else begin
                     acc      <= acc + line_sum_ext;
                     line_cnt <= line_cnt + CNT_W'(1);
                  end
               end
            end

            HOLD: begin
               // Line sums arriving while a result is held are lost; flag it.
               if (line_sum_valid) begin
                  overrun <= 1'b1;
               end
               if (accept) begin
                  window_sum_valid <= 1'b0;
                  state            <= ACCUM;
`ifdef PEAK_TRACK_EN
                  // Strict compare keeps the earliest index on ties.
                  if (window_sum_out > peak_sum_out) begin
                     peak_sum_out <= window_sum_out;
                     peak_idx_out <= win_idx;
                  end
                  win_idx <= win_idx + 16'd1;
`endif
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
